// File: rtl/usart_pkg.sv
// Shared USART definitions: control-field codes, bit-period constants and
// the transmitter state encoding. Used by both halves of the USART.
package usart_pkg;

  // Parity mode field (UPM). The reserved code behaves like "disabled".
  localparam logic [1:0] UPM_DISABLED = 2'b00;
  localparam logic [1:0] UPM_RESERVED = 2'b01;
  localparam logic [1:0] UPM_EVEN     = 2'b10;
  localparam logic [1:0] UPM_ODD      = 2'b11;

  // Character size field (UCSZ). Reserved codes fall back to 8 bits.
  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  // Bit period, in transmit-clock cycles.
  localparam int unsigned PERIOD_ASYNC    = 16;
  localparam int unsigned PERIOD_ASYNC_2X = 8;
  localparam int unsigned PERIOD_SYNC     = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  // Number of data bits for a UCSZ code.
  function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
    case (ucsz)
      UCSZ_5:  return 4'd5;
      UCSZ_6:  return 4'd6;
      UCSZ_7:  return 4'd7;
      UCSZ_8:  return 4'd8;
      UCSZ_9:  return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

  // Last value of the bit timer (P-1) for a speed/mode selection.
  // Sync mode ignores the double-speed bit.
  function automatic logic [3:0] period_max(input logic umsel, input logic u2x);
    if (umsel)    return 4'(PERIOD_SYNC - 1);
    else if (u2x) return 4'(PERIOD_ASYNC_2X - 1);
    else          return 4'(PERIOD_ASYNC - 1);
  endfunction

endpackage

// File: rtl/parity_checker.sv
// Even-parity generator over the low i_frame_size bits of a right-justified
// character. Bits above the character size are ignored.
module parity_checker (
  input  logic [8:0] i_frame,
  input  logic [3:0] i_frame_size,
  output logic       o_parity
);

  // XOR of the bits that belong to the character.
  always_comb begin
    o_parity = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) < i_frame_size) o_parity = o_parity ^ i_frame[i];
    end
  end

endmodule

// File: rtl/transmitter.sv
// USART transmitter: serialises one UDR character per frame onto o_tx as
// start bit, N data bits (MSB first), optional parity, 1 or 2 stop bits.
//
// UDR handshake: i_udr_valid means UDR holds an unsent character. o_udr_load
// is the acceptance strobe; in any cycle where both are high the character on
// i_udr is taken at the next clock edge and UDR may be refilled. Acceptance is
// only possible while idle or in the final cycle of the last stop bit, so a
// waiting character chains onto the previous frame with no idle gap.
module transmitter
  import usart_pkg::*;
(
  input  logic       i_txclk,
  input  logic       i_rst_n,
  input  logic       i_txen,
  input  logic [8:0] i_udr,
  input  logic       i_udr_valid,
  input  logic [1:0] i_upm,
  input  logic [2:0] i_ucsz,
  input  logic       i_usbs,
  input  logic       i_u2x,
  input  logic       i_umsel,
  output logic       o_tx,
  output logic       o_udr_load,
  output logic       o_txc,
  output logic       o_busy
);

  tx_state_e  state_q, state_d;
  logic [3:0] timer_q, timer_d;     // position inside the current bit
  logic [3:0] bits_q, bits_d;       // data bits still to send
  logic [8:0] shift_q, shift_d;     // character, shifted left per data bit
  logic [3:0] n_q, n_d;             // latched character size
  logic       par_en_q, par_en_d;
  logic       odd_q, odd_d;
  logic       two_stop_q, two_stop_d;
  logic [3:0] pmax_q, pmax_d;       // latched bit period minus one
  logic       par_q, par_d;         // parity bit for the frame in flight
  logic       tx_q, tx_d;
  logic       txc_q, txc_d;
  logic       busy_q, busy_d;

  logic       par_raw;
  logic       bit_end;
  logic       last_stop;
  logic       udr_load;
  logic [3:0] tx_idx;

  // The shift register still holds the untouched character during the start
  // bit, which is when the parity result is captured.
  parity_checker u_parity (
    .i_frame      (shift_q),
    .i_frame_size (n_q),
    .o_parity     (par_raw)
  );

  // Next-state, frame sequencing, load strobe and next line level.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bits_d     = bits_q;
    shift_d    = shift_q;
    n_d        = n_q;
    par_en_d   = par_en_q;
    odd_d      = odd_q;
    two_stop_d = two_stop_q;
    pmax_d     = pmax_q;
    par_d      = par_q;
    txc_d      = 1'b0;
    tx_d       = 1'b1;
    tx_idx     = 4'd0;

    bit_end   = (timer_q == pmax_q);
    last_stop = bit_end && (((state_q == STOP1) && !two_stop_q) || (state_q == STOP2));
    udr_load  = i_txen && i_udr_valid && ((state_q == IDLE) || last_stop);

    if (state_q != IDLE) timer_d = bit_end ? 4'd0 : timer_q + 4'd1;

    case (state_q)
      START: begin
        if (timer_q == 4'd0) par_d = par_raw ^ odd_q;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q << 1;
          bits_d  = bits_q - 4'd1;
          if (bits_q == 4'd1) state_d = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: if (bit_end) state_d = STOP1;
      STOP1:  if (bit_end) state_d = two_stop_q ? STOP2 : IDLE;
      STOP2:  if (bit_end) state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Frame complete with nothing chained behind it.
    if (last_stop && !udr_load) txc_d = 1'b1;

    if (udr_load) begin
      state_d    = START;
      timer_d    = 4'd0;
      shift_d    = i_udr;
      n_d        = char_bits(i_ucsz);
      bits_d     = char_bits(i_ucsz);
      par_en_d   = (i_upm == UPM_EVEN) || (i_upm == UPM_ODD);
      odd_d      = (i_upm == UPM_ODD);
      two_stop_d = i_usbs;
      pmax_d     = period_max(i_umsel, i_u2x);
    end

    tx_idx = n_d - 4'd1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[tx_idx];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_txclk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      timer_q    <= 4'd0;
      bits_q     <= 4'd0;
      shift_q    <= 9'd0;
      n_q        <= 4'd0;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      two_stop_q <= 1'b0;
      pmax_q     <= 4'd0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      txc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      par_en_q   <= par_en_d;
      odd_q      <= odd_d;
      two_stop_q <= two_stop_d;
      pmax_q     <= pmax_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      txc_q      <= txc_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_txc      = txc_q;
  assign o_busy     = busy_q;
  assign o_udr_load = udr_load;

endmodule
